// File: rtl/rhythm_pkg.sv
// Shared class encoding and helpers for the rhythm classifier and its
// persistence filter.
package rhythm_pkg;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_AF     = 2'd1,
    CLS_VF     = 2'd2
  } cls_e;

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

  // Bit order is {VF, AF, NORMAL}.
  function automatic logic [2:0] cls_onehot(input cls_e c);
    case (c)
      CLS_NORMAL: return 3'b001;
      CLS_AF:     return 3'b010;
      CLS_VF:     return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/persistence_filter.sv
// Debounce stage: a class change is taken only after the raw class has
// differed from the current class consistently for P consecutive steps.
module persistence_filter
  import rhythm_pkg::*;
#(
  parameter int CNT_WIDTH    = 4,
  parameter int VF_IMMEDIATE = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 step_i,
  input  cls_e                 rc_i,
  input  cls_e                 s_i,
  input  logic [CNT_WIDTH-1:0] p_i,
  output logic                 take_o,
  output cls_e                 next_o
);

  cls_e                 cand_q, cand_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_new;

  always_comb begin
    cand_d  = cand_q;
    cnt_new = cnt_q;
    if (rc_i == s_i) begin
      cnt_new = '0;
    end else if (rc_i == cand_q) begin
      cnt_new = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end else begin
      cand_d  = rc_i;
      cnt_new = CNT_WIDTH'(1);
    end
    // >= so that lowering P below the running count fires on the next match
    take_o = step_i && (rc_i != s_i) &&
             ((cnt_new >= p_i) || ((VF_IMMEDIATE != 0) && (rc_i == CLS_VF)));
    cnt_d  = take_o ? '0 : cnt_new;
    next_o = rc_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cand_q <= CLS_NORMAL;
      cnt_q  <= '0;
    end else if (step_i) begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/rhythm_classifier.sv
// Registered normal/AF/VF classifier with hysteresis, persistence filtering
// and a sticky VF alarm.
module rhythm_classifier
  import rhythm_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_WIDTH    = 4,
  parameter int VF_IMMEDIATE = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  xin_valid,
  input  logic [DATA_WIDTH-1:0] xin,
  input  logic [DATA_WIDTH-1:0] thr1,
  input  logic [DATA_WIDTH-1:0] thr2,
  input  logic [DATA_WIDTH-1:0] hyst,
  input  logic [CNT_WIDTH-1:0]  persist,
  input  logic                  alarm_ack,
  output logic                  out_valid,
  output logic                  normal,
  output logic                  AF,
  output logic                  VF,
  output logic                  class_change,
  output logic                  alarm,
  output logic                  thr_err
);

  logic                  accept, thr_bad, step, take;
  logic [DATA_WIDTH-1:0] lo1, lo2;
  logic [CNT_WIDTH-1:0]  p_eff;
  cls_e                  rc, next_cls;
  cls_e                  state_q, state_d;
  logic                  primed_q, primed_d;
  logic                  alarm_q, alarm_d;
  logic [2:0]            oh_q, oh_d;
  logic                  ov_q, cc_q, terr_q;

  assign accept = en && xin_valid;
  assign thr_bad = thr1 > thr2;
  assign step = accept && !thr_bad;
  assign p_eff = (persist == '0) ? CNT_WIDTH'(1) : persist;
  assign lo1 = DATA_WIDTH'(sat_sub(32'(thr1), 32'(hyst)));
  assign lo2 = DATA_WIDTH'(sat_sub(32'(thr2), 32'(hyst)));

  // Upward moves use thr1/thr2 directly; downward moves need to clear lo1/lo2.
  always_comb begin
    rc = CLS_NORMAL;
    case (state_q)
      CLS_AF: begin
        if (xin > thr2)       rc = CLS_VF;
        else if (xin <= lo1)  rc = CLS_NORMAL;
        else                  rc = CLS_AF;
      end
      CLS_VF: begin
        if (xin > lo2)        rc = CLS_VF;
        else if (xin <= lo1)  rc = CLS_NORMAL;
        else                  rc = CLS_AF;
      end
      default: begin
        if (xin > thr2)       rc = CLS_VF;
        else if (xin > thr1)  rc = CLS_AF;
        else                  rc = CLS_NORMAL;
      end
    endcase
  end

  persistence_filter #(
    .CNT_WIDTH    (CNT_WIDTH),
    .VF_IMMEDIATE (VF_IMMEDIATE)
  ) u_filter (
    .clk    (clk),
    .rstn   (rstn),
    .step_i (step),
    .rc_i   (rc),
    .s_i    (state_q),
    .p_i    (p_eff),
    .take_o (take),
    .next_o (next_cls)
  );

  always_comb begin
    state_d  = take ? next_cls : state_q;
    primed_d = primed_q | step;
    alarm_d  = alarm_q;
    if (alarm_ack && (state_q != CLS_VF)) alarm_d = 1'b0;
    if (take && (next_cls == CLS_VF))     alarm_d = 1'b1;
    oh_d = primed_d ? cls_onehot(state_d) : 3'b000;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= CLS_NORMAL;
      primed_q <= 1'b0;
      alarm_q  <= 1'b0;
      oh_q     <= 3'b000;
      ov_q     <= 1'b0;
      cc_q     <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      primed_q <= primed_d;
      alarm_q  <= alarm_d;
      oh_q     <= oh_d;
      ov_q     <= step;
      cc_q     <= take;
      terr_q   <= accept && thr_bad;
    end
  end

  assign out_valid    = ov_q;
  assign normal       = oh_q[0];
  assign AF           = oh_q[1];
  assign VF           = oh_q[2];
  assign class_change = cc_q;
  assign alarm        = alarm_q;
  assign thr_err      = terr_q;

endmodule

// File: tb/tb_rhythm_classifier.sv
// Directed bench for rhythm_classifier with a queue of expected output
// vectors {out_valid, VF, AF, normal, class_change, alarm, thr_err}.
module tb_rhythm_classifier;

  typedef struct packed {
    logic       ov;
    logic [2:0] cls;
    logic       cc;
    logic       al;
    logic       te;
  } exp_t;

  localparam logic [2:0] ZZ = 3'b000, NN = 3'b001, AA = 3'b010, VV = 3'b100;

  logic        clk = 1'b0;
  logic        rstn, en, xin_valid, alarm_ack;
  logic [15:0] xin, thr1, thr2, hyst;
  logic [3:0]  persist;

  logic ov0, n0, a0, v0, cc0, al0, te0;
  logic ov1, n1, a1, v1, cc1, al1, te1;

  int   npass = 0;
  int   ntot  = 0;
  exp_t q[$];
  exp_t got1;

  always #5 clk = ~clk;

  rhythm_classifier #(.DATA_WIDTH(16), .CNT_WIDTH(4), .VF_IMMEDIATE(0)) dut0 (
    .clk(clk), .rstn(rstn), .en(en), .xin_valid(xin_valid), .xin(xin),
    .thr1(thr1), .thr2(thr2), .hyst(hyst), .persist(persist), .alarm_ack(alarm_ack),
    .out_valid(ov0), .normal(n0), .AF(a0), .VF(v0), .class_change(cc0),
    .alarm(al0), .thr_err(te0));

  rhythm_classifier #(.DATA_WIDTH(16), .CNT_WIDTH(4), .VF_IMMEDIATE(1)) dut1 (
    .clk(clk), .rstn(rstn), .en(en), .xin_valid(xin_valid), .xin(xin),
    .thr1(thr1), .thr2(thr2), .hyst(hyst), .persist(persist), .alarm_ack(alarm_ack),
    .out_valid(ov1), .normal(n1), .AF(a1), .VF(v1), .class_change(cc1),
    .alarm(al1), .thr_err(te1));

  function automatic exp_t E(input logic ov, input logic [2:0] cls, input logic cc,
                             input logic al, input logic te);
    exp_t e;
    e.ov = ov; e.cls = cls; e.cc = cc; e.al = al; e.te = te;
    return e;
  endfunction

  function automatic exp_t obs0();
    return E(ov0, {v0, a0, n0}, cc0, al0, te0);
  endfunction

  task automatic chk(input string tag, input exp_t obs, input exp_t exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic step(input logic v, input logic [15:0] x, input logic ack,
                      input exp_t e, input string tag);
    exp_t ex;
    @(negedge clk);
    xin_valid = v;
    xin       = x;
    alarm_ack = ack;
    q.push_back(e);
    @(posedge clk);
    #1;
    got1 = E(ov1, {v1, a1, n1}, cc1, al1, te1);
    ex = q.pop_front();
    chk(tag, obs0(), ex);
    xin_valid = 1'b0;
    alarm_ack = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; xin_valid = 1'b0; xin = '0; alarm_ack = 1'b0;
    thr1 = 16'd100; thr2 = 16'd200; hyst = 16'd10; persist = 4'd3;
    repeat (2) @(negedge clk);
    chk("in_reset", obs0(), E(0, ZZ, 0, 0, 0));
    rstn = 1'b1;

    step(0, 16'd0,  0, E(0, ZZ, 0, 0, 0), "unprimed_idle");
    step(1, 16'd50, 0, E(1, NN, 0, 0, 0), "first_normal");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "af_cnt1");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "af_cnt2");
    step(1, 16'd150, 0, E(1, AA, 1, 0, 0), "to_af");
    step(0, 16'd0,   0, E(0, AA, 0, 0, 0), "af_hold");
    repeat (3) step(1, 16'd95, 0, E(1, AA, 0, 0, 0), "af_hyst_95");
    step(1, 16'd90, 0, E(1, AA, 0, 0, 0), "down_cnt1");
    step(1, 16'd90, 0, E(1, AA, 0, 0, 0), "down_cnt2");
    step(1, 16'd90, 0, E(1, NN, 1, 0, 0), "af_to_normal");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "outlier_a");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "outlier_b");
    step(1, 16'd50,  0, E(1, NN, 0, 0, 0), "outlier_reset");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "outlier_c");

    step(1, 16'd250, 0, E(1, NN, 0, 0, 0), "vf_cnt1");
    step(1, 16'd250, 0, E(1, NN, 0, 0, 0), "vf_cnt2");
    step(1, 16'd250, 0, E(1, VV, 1, 1, 0), "to_vf");
    step(0, 16'd0,   1, E(0, VV, 0, 1, 0), "ack_ignored_in_vf");
    step(1, 16'd50,  0, E(1, VV, 0, 1, 0), "vf_down1");
    step(1, 16'd50,  0, E(1, VV, 0, 1, 0), "vf_down2");
    step(1, 16'd50,  0, E(1, NN, 1, 1, 0), "vf_to_normal");
    step(0, 16'd0,   1, E(0, NN, 0, 0, 0), "ack_clears");

    thr1 = 16'd300;
    step(1, 16'd250, 0, E(0, NN, 0, 0, 1), "thr_err");
    thr1 = 16'd100;
    step(0, 16'd0,   0, E(0, NN, 0, 0, 0), "thr_err_pulse");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "after_drop1");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "after_drop2");
    step(1, 16'd150, 0, E(1, AA, 1, 0, 0), "after_drop_af");

    hyst = 16'd150;
    step(1, 16'd5, 0, E(1, AA, 0, 0, 0), "lo1_sat_5");
    step(1, 16'd0, 0, E(1, AA, 0, 0, 0), "lo1_sat_0a");
    step(1, 16'd0, 0, E(1, AA, 0, 0, 0), "lo1_sat_0b");
    step(1, 16'd0, 0, E(1, NN, 1, 0, 0), "lo1_sat_normal");
    hyst = 16'd10;

    en = 1'b0;
    step(1, 16'd150, 0, E(0, NN, 0, 0, 0), "en0_a");
    step(1, 16'd150, 0, E(0, NN, 0, 0, 0), "en0_b");
    en = 1'b1;
    persist = 4'd0;
    step(1, 16'd150, 0, E(1, AA, 1, 0, 0), "persist0_af");
    step(1, 16'd50,  0, E(1, NN, 1, 0, 0), "persist0_normal");

    persist = 4'd3;
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "pchg_cnt1");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "pchg_cnt2");
    persist = 4'd1;
    step(1, 16'd150, 0, E(1, AA, 1, 0, 0), "pchg_fire");
    step(1, 16'd250, 0, E(1, VV, 1, 1, 0), "p1_vf");
    step(1, 16'd50,  0, E(1, NN, 1, 1, 0), "p1_normal");
    en = 1'b0;
    step(0, 16'd0, 1, E(0, NN, 0, 0, 0), "ack_with_en0");
    en = 1'b1;
    step(1, 16'd250, 1, E(1, VV, 1, 1, 0), "set_wins_over_ack");
    step(1, 16'd50,  0, E(1, NN, 1, 1, 0), "set_wins_normal");
    step(0, 16'd0,   1, E(0, NN, 0, 0, 0), "set_wins_ack");

    persist = 4'd3;
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "prerst_cnt1");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "prerst_cnt2");
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("async_reset", obs0(), E(0, ZZ, 0, 0, 0));
    @(negedge clk);
    rstn = 1'b1;
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "postrst_cnt1");
    step(1, 16'd150, 0, E(1, NN, 0, 0, 0), "postrst_cnt2");
    step(1, 16'd150, 0, E(1, AA, 1, 0, 0), "postrst_af");

    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(1, 16'd201, 0, E(1, NN, 0, 0, 0), "vfimm_off");
    chk("vfimm_on", got1, E(1, VV, 1, 1, 0));

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
